fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 113 +++++++++++
 tb/tb_fetch_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, arbitrates the instruction-memory
// write port between the program loader and execution, and detects end of program.
module fetch_sequencer #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           MEM_DEPTH  = 256,
  parameter logic [ADDR_WIDTH-1:0] END_ADDR   = 'h20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic                         stall,
  input  logic                         jump,
  input  logic [ADDR_WIDTH-1:0]        jump_target,
  input  logic                         branch_taken,
  input  logic [ADDR_WIDTH-1:0]        branch_target,
  input  logic                         load_req,
  input  logic                         load_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         fetch_valid,
  output logic                         load_gnt,
  output logic                         imem_we,
  output logic [$clog2(MEM_DEPTH)-1:0] imem_waddr,
  output logic [31:0]                  imem_wdata,
  output logic                         halted,
  output logic [15:0]                  instr_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_e;

  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   pc_q;
  logic [ADDR_WIDTH-1:0]   pc_d;
  logic [15:0]             cnt_q;
  logic                    fetch_valid_q;
  logic                    halted_q;
  logic                    load_gnt_q;
  logic                    in_load;

  function automatic logic [ADDR_WIDTH-1:0] align_word(input logic [ADDR_WIDTH-1:0] a);
    return {a[ADDR_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    return (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  // A stalled redirect is dropped outright; nothing is remembered for later.
  always_comb begin
    pc_d = pc_q + ADDR_WIDTH'(4);
    if (stall)             pc_d = pc_q;
    else if (jump)         pc_d = align_word(jump_target);
    else if (branch_taken) pc_d = align_word(branch_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= '0;
      cnt_q         <= '0;
      fetch_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      load_gnt_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, HALT: begin
          if (load_req) begin
            state_q       <= LOAD;
            load_gnt_q    <= 1'b1;
            halted_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
          end else if (run) begin
            state_q       <= RUN;
            pc_q          <= '0;
            cnt_q         <= '0;
            halted_q      <= 1'b0;
            fetch_valid_q <= 1'b1;
          end
        end
        LOAD: begin
          if (!load_req) begin
            state_q    <= IDLE;
            load_gnt_q <= 1'b0;
          end
        end
        RUN: begin
          pc_q <= pc_d;
          if (!stall) cnt_q <= sat_inc(cnt_q);
          // Any next PC at or past the end address (unsigned) ends the program.
          if (pc_d >= END_ADDR) begin
            state_q       <= HALT;
            halted_q      <= 1'b1;
            fetch_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_load     = (state_q == LOAD);
  assign imem_we     = in_load & load_we;
  assign imem_waddr  = in_load ? load_addr : '0;
  assign imem_wdata  = in_load ? load_data : '0;

  assign pc          = pc_q;
  assign instr_count = cnt_q;
  assign fetch_valid = fetch_valid_q;
  assign halted      = halted_q;
  assign load_gnt    = load_gnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected states are queued as stimulus is
// applied and compared once the DUT has responded.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run, stall, jump, branch_taken;
  logic [31:0] jump_target, branch_target;
  logic        load_req, load_we;
  logic [7:0]  load_addr;
  logic [31:0] load_data;
  logic [31:0] pc;
  logic        fetch_valid, load_gnt, imem_we, halted;
  logic [7:0]  imem_waddr;
  logic [31:0] imem_wdata;
  logic [15:0] instr_count;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] pc;
    logic        fv;
    logic        h;
    logic        g;
    logic [15:0] cnt;
    bit          full;
  } exp_t;

  exp_t exp_q[$];

  fetch_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .stall(stall), .jump(jump),
    .jump_target(jump_target), .branch_taken(branch_taken), .branch_target(branch_target),
    .load_req(load_req), .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .pc(pc), .fetch_valid(fetch_valid), .load_gnt(load_gnt), .imem_we(imem_we),
    .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .halted(halted),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [31:0] p, input logic fv,
                          input logic h, input logic g, input logic [15:0] c, input bit full);
    exp_t e;
    e.tag = tag; e.pc = p; e.fv = fv; e.h = h; e.g = g; e.cnt = c; e.full = full;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
      return;
    end
    e = exp_q.pop_front();
    if (e.full) begin
      cmp({e.tag, ".pc"}, pc, e.pc);
      cmp({e.tag, ".instr_count"}, {16'd0, instr_count}, {16'd0, e.cnt});
    end
    cmp({e.tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e.fv});
    cmp({e.tag, ".halted"}, {31'd0, halted}, {31'd0, e.h});
    cmp({e.tag, ".load_gnt"}, {31'd0, load_gnt}, {31'd0, e.g});
  endtask

  task automatic step(input string tag, input logic [31:0] p, input logic fv,
                      input logic h, input logic g, input logic [15:0] c, input bit full);
    push_exp(tag, p, fv, h, g, c, full);
    tick();
    pop_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; run = 0; stall = 0; jump = 0; branch_taken = 0;
    jump_target = '0; branch_target = '0;
    load_req = 0; load_we = 0; load_addr = '0; load_data = '0;

    push_exp("reset", 32'h0, 0, 0, 0, 16'd0, 1);
    #2;
    pop_check();
    cmp("reset.imem_we", {31'd0, imem_we}, 32'd0);
    tick();
    rst_n = 1'b1;
    step("idle_hold", 32'h0, 0, 0, 0, 16'd0, 1);

    // Straight-line program to the end address.
    run = 1;
    step("run_entry", 32'h0, 1, 0, 0, 16'd0, 1);
    run = 0;
    for (int i = 1; i < 8; i++) step("seq", 32'(4 * i), 1, 0, 0, 16'(i), 1);
    step("halt", 32'h20, 0, 1, 0, 16'd8, 1);
    step("halt_hold", 32'h20, 0, 1, 0, 16'd8, 1);

    // Restart from HALT, then redirect priority and stall behaviour.
    run = 1;
    step("restart", 32'h0, 1, 0, 0, 16'd0, 1);
    run = 0;
    for (int i = 1; i < 5; i++) step("seq2", 32'(4 * i), 1, 0, 0, 16'(i), 1);
    jump = 1; jump_target = 32'h12; branch_taken = 1; branch_target = 32'h08;
    step("jump_over_branch", 32'h10, 1, 0, 0, 16'd5, 1);
    jump = 0; branch_taken = 0;
    step("after_jump", 32'h14, 1, 0, 0, 16'd6, 1);
    jump = 1; jump_target = 32'h08;
    step("jump_back", 32'h08, 1, 0, 0, 16'd7, 1);
    stall = 1; jump_target = 32'h18;
    for (int i = 0; i < 3; i++) step("stall_hold", 32'h08, 1, 0, 0, 16'd7, 1);
    stall = 0; jump = 0;
    step("stall_release", 32'h0C, 1, 0, 0, 16'd8, 1);
    branch_taken = 1; branch_target = 32'h1B;
    step("branch_align", 32'h18, 1, 0, 0, 16'd9, 1);
    branch_taken = 0; jump = 1; jump_target = 32'hFFFF_FFFF;
    step("jump_far_halt", 32'hFFFF_FFFC, 0, 1, 0, 16'd10, 1);
    jump = 0;

    // Asynchronous reset from HALT, between clock edges.
    rst_n = 1'b0;
    push_exp("async_rst_halt", 32'h0, 0, 0, 0, 16'd0, 1);
    #1;
    pop_check();
    #2;
    rst_n = 1'b1;
    step("idle_after_rst", 32'h0, 0, 0, 0, 16'd0, 1);

    // Loader wins over run in IDLE; write port follows loader combinationally.
    load_req = 1; run = 1;
    step("load_entry", 32'h0, 0, 0, 1, 16'd0, 1);
    load_we = 1; load_addr = 8'd5; load_data = 32'h2210_FFFF;
    #1;
    cmp("load.imem_we", {31'd0, imem_we}, 32'd1);
    cmp("load.imem_waddr", {24'd0, imem_waddr}, 32'd5);
    cmp("load.imem_wdata", imem_wdata, 32'h2210_FFFF);
    load_we = 0;
    #1;
    cmp("load.we_low", {31'd0, imem_we}, 32'd0);
    load_req = 0;
    step("load_exit", 32'h0, 0, 0, 0, 16'd0, 1);
    cmp("idle.imem_waddr", {24'd0, imem_waddr}, 32'd0);
    cmp("idle.imem_wdata", imem_wdata, 32'd0);

    // Load request during RUN is held off until HALT.
    step("run_from_idle", 32'h0, 1, 0, 0, 16'd0, 1);
    run = 0; load_req = 1; load_we = 1; load_addr = 8'd3; load_data = 32'hA5A5_0001;
    for (int i = 1; i < 8; i++) begin
      step("run_no_gnt", 32'(4 * i), 1, 0, 0, 16'(i), 1);
      cmp("run_no_gnt.imem_we", {31'd0, imem_we}, 32'd0);
    end
    step("halt_no_gnt", 32'h20, 0, 1, 0, 16'd8, 1);
    step("halt_to_load", 32'h0, 0, 0, 1, 16'd0, 0);
    cmp("halt_to_load.imem_we", {31'd0, imem_we}, 32'd1);
    load_req = 0; load_we = 0;
    step("load_to_idle", 32'h0, 0, 0, 0, 16'd0, 0);

    // Asynchronous reset in the middle of RUN.
    run = 1;
    step("run3", 32'h0, 1, 0, 0, 16'd0, 1);
    run = 0;
    for (int i = 1; i < 4; i++) step("seq3", 32'(4 * i), 1, 0, 0, 16'(i), 1);
    #2;
    rst_n = 1'b0;
    push_exp("async_rst_run", 32'h0, 0, 0, 0, 16'd0, 1);
    #1;
    pop_check();
    #2;
    rst_n = 1'b1;
    run = 1;
    step("run_after_rst", 32'h0, 1, 0, 0, 16'd0, 1);
    run = 0;
    step("run_after_rst2", 32'h4, 1, 0, 0, 16'd1, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
